// File: rtl/fpu_scoreboard_if.sv
// Issue, decode-hazard and write-back signals shared between the FP pipeline
// and the in-flight op scoreboard.
interface fpu_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [2:0] issue_lat;
  logic       issue_ready;
  logic [4:0] rs1i;
  logic [4:0] rs2i;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       busy;

  modport master (
    output issue_valid, issue_rd, issue_lat, rs1i, rs2i, use_rs1, use_rs2, flush,
    input  issue_ready, hazard, wb_valid, wb_rd, busy
  );

  modport slave (
    input  issue_valid, issue_rd, issue_lat, rs1i, rs2i, use_rs1, use_rs2, flush,
    output issue_ready, hazard, wb_valid, wb_rd, busy
  );
endinterface

// File: rtl/fpu_scoreboard.sv
// Four-entry FP scoreboard: tracks in-flight ops by destination and remaining
// latency, arbitrates the single write-back port and flags RAW hazards.
module fpu_scoreboard (
  input  logic            clk,
  input  logic            rst,
  fpu_scoreboard_if.slave sb
);
  localparam int ENTRIES = 4;

  logic [ENTRIES-1:0] ent_valid;
  logic [4:0]         ent_rd  [ENTRIES];
  logic [2:0]         ent_cnt [ENTRIES];

  logic [ENTRIES-1:0] retire;
  logic [ENTRIES-1:0] free_ent;
  logic [ENTRIES-1:0] alloc_oh;
  logic [ENTRIES-1:0] waw_hit;
  logic [ENTRIES-1:0] coll_hit;
  logic [ENTRIES-1:0] rd_hit;
  logic [3:0]         lat_plus1;
  logic [4:0]         wb_rd_sel;
  logic               full;
  logic               ready;
  logic               accept;

  always_comb begin
    lat_plus1 = {1'b0, sb.issue_lat} + 4'd1;
    wb_rd_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      retire[i]   = ent_valid[i] && (ent_cnt[i] == 3'd1);
      waw_hit[i]  = ent_valid[i] && (ent_rd[i] == sb.issue_rd);
      // A new op of latency L lands on the same edge as an entry holding cnt L+1.
      coll_hit[i] = ent_valid[i] && ({1'b0, ent_cnt[i]} == lat_plus1);
      rd_hit[i]   = ent_valid[i] &&
                    ((sb.use_rs1 && (sb.rs1i == ent_rd[i])) ||
                     (sb.use_rs2 && (sb.rs2i == ent_rd[i])));
      if (retire[i]) wb_rd_sel = ent_rd[i];
    end

    // An entry retiring this edge is reusable by the op issuing this cycle.
    free_ent = ~ent_valid | retire;
    alloc_oh = free_ent & (~free_ent + ENTRIES'(1));
    full     = ~|free_ent;

    ready  = !full && (sb.issue_lat != 3'd0) && !(|waw_hit) && !(|coll_hit) && !sb.flush;
    accept = sb.issue_valid && ready;

    sb.issue_ready = ready;
    sb.wb_valid    = (|retire) && !sb.flush;
    sb.wb_rd       = sb.wb_valid ? wb_rd_sel : 5'd0;
    sb.hazard      = (|rd_hit) && !sb.flush;
    sb.busy        = |ent_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_rd[i]  <= '0;
        ent_cnt[i] <= '0;
      end
    end else if (sb.flush) begin
      ent_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (accept && alloc_oh[i]) begin
          ent_valid[i] <= 1'b1;
          ent_rd[i]    <= sb.issue_rd;
          ent_cnt[i]   <= sb.issue_lat;
        end else if (ent_valid[i]) begin
          ent_cnt[i] <= ent_cnt[i] - 3'd1;
          if (retire[i]) ent_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule
